// File: rtl/fetch_queue_t.sv
// Byte-granular instruction prefetch queue: loads the reset vector, streams bytes
// from memory ahead of the decoder and presents one 1-3 byte instruction per handshake.
module fetch_queue_t #(
    parameter int                 ADDR_W         = 16,
    parameter int                 DEPTH          = 4,
    parameter int                 BUS_BYTES      = 1,
    parameter bit                 USE_RESET_VEC  = 1'b1,
    parameter logic [ADDR_W-1:0]  RESET_VEC_ADDR = 16'hFFFC,
    parameter logic [ADDR_W-1:0]  RESET_PC       = '0
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    output logic                   mem_req_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    input  logic                   mem_valid_i,
    input  logic [8*BUS_BYTES-1:0] mem_data_i,
    input  logic                   flush_i,
    input  logic [ADDR_W-1:0]      flush_pc_i,
    input  logic [1:0]             instr_len_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [7:0]             opcode_o,
    output logic [15:0]            operand_o,
    output logic [ADDR_W-1:0]      instr_pc_o
);

    typedef enum logic {
        ST_VEC = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam int                CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  BB_C    = CNT_W'(BUS_BYTES);
    localparam logic [ADDR_W-1:0] BB_A    = ADDR_W'(BUS_BYTES);

    state_t            state;
    logic              started;
    logic              vec_phase;
    logic [7:0]        vec_lo;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] pc;
    logic [IDX_W-1:0]  head;
    logic [CNT_W-1:0]  count;
    logic [7:0]        q [DEPTH];

    logic [1:0]        len_eff;
    logic [IDX_W-1:0]  tail;
    logic              beat_done;
    logic              consume;
    logic              fill;
    logic [15:0]       data16;
    logic [ADDR_W-1:0] vec_target;
    logic [CNT_W-1:0]  fill_amt;
    logic [CNT_W-1:0]  cons_amt;

    // NOTE: every signal is assigned on every path through this block, so no latch can be inferred.
    always_comb begin
        len_eff       = (instr_len_i == 2'd0) ? 2'd1 : instr_len_i;
        // started keeps the request low for the first cycle out of reset
        mem_req_o     = started && (state == ST_VEC || (DEPTH_C - count) >= BB_C);
        mem_addr_o    = fetch_addr;
        instr_valid_o = (state == ST_RUN) && (count >= CNT_W'(len_eff));
        beat_done     = mem_req_o && mem_valid_i;
        consume       = instr_valid_o && instr_ready_i;
        fill          = beat_done && (state == ST_RUN) && !flush_i;
        tail          = head + count[IDX_W-1:0];
        data16        = 16'(mem_data_i);
        vec_target    = (BUS_BYTES == 2) ? ADDR_W'(data16) : ADDR_W'({data16[7:0], vec_lo});
        fill_amt      = fill ? BB_C : '0;
        cons_amt      = consume ? CNT_W'(len_eff) : '0;
        opcode_o      = q[head];
        operand_o     = {(len_eff == 2'd3) ? q[head + IDX_W'(2)] : 8'h00,
                         (len_eff >= 2'd2) ? q[head + IDX_W'(1)] : 8'h00};
        instr_pc_o    = pc;
    end

    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state      <= USE_RESET_VEC ? ST_VEC : ST_RUN;
            started    <= 1'b0;
            vec_phase  <= 1'b0;
            vec_lo     <= 8'h00;
            fetch_addr <= USE_RESET_VEC ? RESET_VEC_ADDR : RESET_PC;
            pc         <= RESET_PC;
            head       <= '0;
            count      <= '0;
        end else begin
            started <= 1'b1;
            if (flush_i) begin
                // redirect wins over any beat or consume landing in the same cycle
                state      <= ST_RUN;
                count      <= '0;
                fetch_addr <= flush_pc_i;
                pc         <= flush_pc_i;
                vec_phase  <= 1'b0;
            end else if (state == ST_VEC) begin
                if (beat_done) begin
                    if (BUS_BYTES == 2 || vec_phase) begin
                        state      <= ST_RUN;
                        fetch_addr <= vec_target;
                        pc         <= vec_target;
                        vec_phase  <= 1'b0;
                    end else begin
                        vec_lo     <= data16[7:0];
                        vec_phase  <= 1'b1;
                        fetch_addr <= fetch_addr + ADDR_W'(1);
                    end
                end
            end else begin
                if (beat_done) begin
                    fetch_addr <= fetch_addr + BB_A;
                end
                if (consume) begin
                    head <= head + IDX_W'(len_eff);
                    pc   <= pc + ADDR_W'(len_eff);
                end
                count <= count + fill_amt - cons_amt;
            end
        end
    end

    // NOTE: queue storage has no reset; count alone decides which bytes are meaningful.
    always_ff @(posedge clk_i) begin
        if (rstn_i && fill) begin
            for (int i = 0; i < BUS_BYTES; i++) begin
                q[tail + IDX_W'(i)] <= mem_data_i[8*i +: 8];
            end
        end
    end

    a_count_le_depth: assert property (@(posedge clk_i) disable iff (!rstn_i)
        count <= DEPTH_C);
    a_consume_has_bytes: assert property (@(posedge clk_i) disable iff (!rstn_i)
        consume |-> (state == ST_RUN && count >= CNT_W'(len_eff)));
    a_fill_has_space: assert property (@(posedge clk_i) disable iff (!rstn_i)
        fill |-> ((DEPTH_C - count) >= BB_C));

endmodule
